data_mem_cache: RTL and testbench
=================================

Name: data_mem_cache

Overview:
- Parametrised successor to the single-configuration data memory.
- Direct-mapped, one-word-per-line, write-through, read-allocate cache in front of an internal backing word RAM with configurable access latency.
- Keeps the existing load/store interface: byte, halfword and word access via sign_mask, sign extension, LED register and clk_stall to the CPU.
- Sits on the processor's MEM stage.

Parameters:
- LINES, 16, number of cache lines; power of 2, ≥2.
- BACKING_WORDS, 1024, backing RAM depth in 32-bit words; power of 2, > LINES.
- MEM_LATENCY, 2, backing access wait cycles; ≥1.
- LED_ADDR, 32'h2000, byte address of the LED register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  byte address.
- write_data  in  32  store data, right-aligned.
- memwrite  in  1  store request.
- memread  in  1  load request.
- sign_mask  in  4  access size and signedness:
  - [2:0]: 001 = byte, 011 = half, 111 = word.
  - [3]: sign-extend the load.
- read_data  out  32  load result, registered.
- led  out  8  LED register.
- clk_stall  out  1  high while an access is in progress; CPU holds its inputs.

Behaviour:
- Reset, synchronous: state=IDLE, all valid bits cleared, read_data=0, led=0, clk_stall=0. Backing RAM contents are kept. Reset mid-operation aborts the access; a pending backing write is dropped.
- Address split:
  - word = addr[WB+1:2], with WB = log2(BACKING_WORDS); higher address bits are ignored, so accesses wrap modulo the RAM size.
  - index = word[log2(LINES)-1:0]; tag = remaining word bits.
  - Byte lane = addr[1:0]. Halfword lane = addr[1]; addr[0] is ignored. Word access ignores addr[1:0].
- Requests are sampled only in IDLE. memwrite and memread together: the write wins and the read is dropped. Inputs seen while not IDLE are ignored.
- States IDLE, RD_MISS, WR_BUSY:
  - IDLE, read hit (valid and tag match): read_data is updated at the next edge. clk_stall stays 0. Latency is 1 cycle.
  - IDLE, read miss: go to RD_MISS. clk_stall is registered high from the next edge. A counter runs MEM_LATENCY cycles, then the line is filled (valid=1, tag written), read_data is updated and clk_stall falls. Stall lasts exactly MEM_LATENCY+1 cycles.
  - IDLE, write: go to WR_BUSY with clk_stall high.
    - The backing word is read-modify-written: only the lanes selected by sign_mask are replaced, taken from write_data[7:0] or write_data[15:0].
    - The write completes after MEM_LATENCY cycles; stall length is MEM_LATENCY+1.
    - On a tag hit, the cache line is updated identically in the same final cycle. On a miss there is no allocation.
- Load data formatting:
  - The selected lane is right-aligned.
  - Bits above the lane are zero-filled, or filled with the lane's MSB when sign_mask[3]=1.
  - Word loads ignore sign_mask[3].
- LED:
  - A store whose word address matches LED_ADDR>>2 also sets led = write_data[7:0], at the store's completion edge.
  - Loads from LED_ADDR return the backing word, not led.
- Invalid sign_mask[2:0] codes are treated as word accesses.
- read_data holds its value between loads.

Optional Feature:
- Macro DATA_MEM_PERF_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments once per completed read hit or read miss.
  - Writes are not counted.
  - Both counters saturate at 32'hFFFFFFFF and clear on reset.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Store byte, addr=0x400, write_data=0xAAA, sign_mask=0001 → clk_stall high 3 cycles (MEM_LATENCY=2). Then load with sign_mask=1001 → read miss, 3 stall cycles, read_data=0xFFFFFFAA. Then load with sign_mask=0001 → hit, no stall, read_data=0x000000AA next cycle.
- Store half, addr=0x100, write_data=0x2AAAA, sign_mask=0011 → load with sign_mask=1011 returns 0xFFFFAAAA; load with sign_mask=0011 returns 0x0000AAAA.
- Store word, addr=0x40, write_data=0xAAAAAAAA → word load returns 0xAAAAAAAA. Store byte 0x55 at addr=0x41 → word load returns 0xAAAA55AA, confirming hit-update and lane merge.
- Conflict: load 0x40 (miss), load 0x80 (same index with LINES=16, miss), load 0x40 again → miss, 3 stall cycles. With DATA_MEM_PERF_EN defined: miss_count=3, hit_count=0.
- Store word 0x000000C3 to LED_ADDR → led=0xC3 at the completion edge. Assert reset during the following read miss → next cycle clk_stall=0, read_data=0, led=0; a subsequent load of 0x40 misses.
- Assert memwrite and memread together at addr=0x200 with write_data=0x12345678 → treated as a write (3 stall cycles, no read_data change). A later load returns 0x12345678.

Source files
------------

// File: rtl/data_mem_cache.sv
// Direct-mapped, write-through, read-allocate data cache over a backing word RAM with modelled access latency.
// Define DATA_MEM_PERF_EN to add the hit_count / miss_count outputs.
module data_mem_cache #(
  parameter int          LINES         = 16,
  parameter int          BACKING_WORDS = 1024,
  parameter int          MEM_LATENCY   = 2,
  parameter logic [31:0] LED_ADDR      = 32'h2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic        memwrite,
  input  logic        memread,
  input  logic [3:0]  sign_mask,
  output logic [31:0] read_data,
  output logic [7:0]  led,
  output logic        clk_stall
`ifdef DATA_MEM_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  // state   | meaning
  // IDLE    | accepting requests; read hits complete here
  // RD_MISS | waiting on backing RAM, then filling the line
  // WR_BUSY | waiting on backing RAM, then merging the store
  typedef enum logic [1:0] {IDLE, RD_MISS, WR_BUSY} state_t;

  localparam int WB = $clog2(BACKING_WORDS);
  localparam int IB = $clog2(LINES);
  localparam int TW = WB - IB;
  localparam int CW = $clog2(MEM_LATENCY + 1);

  logic [31:0] mem      [BACKING_WORDS];
  logic [TW-1:0] tag_mem [LINES];
  logic [31:0] line_mem [LINES];

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WB-1:0] word_q, word_d;
  logic [1:0]    lo_q, lo_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    mask_q, mask_d;
  logic          led_sel_q, led_sel_d;
  logic [31:0]   read_data_q, read_data_d;
  logic [7:0]    led_q, led_d;
  logic          stall_q, stall_d;
  logic [LINES-1:0] valid_q, valid_d;
`ifdef DATA_MEM_PERF_EN
  logic [31:0]   hit_cnt_q, hit_cnt_d;
  logic [31:0]   miss_cnt_q, miss_cnt_d;
`endif

  logic [WB-1:0] req_word;
  logic [IB-1:0] req_idx, cur_idx;
  logic [TW-1:0] req_tag, cur_tag;
  logic          req_hit, cur_hit;
  logic [31:0]   back_word, merged_word, line_data;
  logic          mem_we, line_we;

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [3:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (m[2:0])
      3'b001:  return {{24{m[3] & b[7]}}, b};
      3'b011:  return {{16{m[3] & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [1:0] lo, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    case (m[2:0])
      3'b001: r[{lo, 3'b000} +: 8] = wd[7:0];
      3'b011: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: r = wd;
    endcase
    return r;
  endfunction

  // Higher address bits are dropped here, so memory accesses wrap modulo the RAM size.
  assign req_word    = addr[WB+1:2];
  assign req_idx     = req_word[IB-1:0];
  assign req_tag     = req_word[WB-1:IB];
  assign req_hit     = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);
  assign cur_idx     = word_q[IB-1:0];
  assign cur_tag     = word_q[WB-1:IB];
  assign cur_hit     = valid_q[cur_idx] && (tag_mem[cur_idx] == cur_tag);
  assign back_word   = mem[word_q];
  assign merged_word = store_merge(back_word, wdata_q, lo_q, mask_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    led_sel_d   = led_sel_q;
    read_data_d = read_data_q;
    led_d       = led_q;
    stall_d     = stall_q;
    valid_d     = valid_q;
    mem_we      = 1'b0;
    line_we     = 1'b0;
    line_data   = back_word;
`ifdef DATA_MEM_PERF_EN
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (memwrite || memread) begin
          word_d    = req_word;
          lo_d      = addr[1:0];
          wdata_d   = write_data;
          mask_d    = sign_mask;
          led_sel_d = (addr[31:2] == LED_ADDR[31:2]);
          if (memwrite) begin
            state_d = WR_BUSY;
            cnt_d   = CW'(MEM_LATENCY);
            stall_d = 1'b1;
          end else if (req_hit) begin
            read_data_d = load_fmt(line_mem[req_idx], addr[1:0], sign_mask);
`ifdef DATA_MEM_PERF_EN
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 32'd1;
`endif
          end else begin
            state_d = RD_MISS;
            cnt_d   = CW'(MEM_LATENCY);
            stall_d = 1'b1;
          end
        end
      end
      RD_MISS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          valid_d[cur_idx] = 1'b1;
          line_we          = 1'b1;
          read_data_d      = load_fmt(back_word, lo_q, mask_q);
          state_d          = IDLE;
          stall_d          = 1'b0;
`ifdef DATA_MEM_PERF_EN
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
`endif
        end
      end
      WR_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          // Write-through: backing word always, cache line only if already resident.
          mem_we    = 1'b1;
          line_we   = cur_hit;
          line_data = merged_word;
          if (led_sel_q) led_d = wdata_q[7:0];
          state_d   = IDLE;
          stall_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (reset) begin
      mem_we  = 1'b0;
      line_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      lo_q        <= '0;
      wdata_q     <= '0;
      mask_q      <= '0;
      led_sel_q   <= 1'b0;
      read_data_q <= '0;
      led_q       <= '0;
      stall_q     <= 1'b0;
      valid_q     <= '0;
`ifdef DATA_MEM_PERF_EN
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      led_sel_q   <= led_sel_d;
      read_data_q <= read_data_d;
      led_q       <= led_d;
      stall_q     <= stall_d;
      valid_q     <= valid_d;
`ifdef DATA_MEM_PERF_EN
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[word_q] <= merged_word;
    if (line_we) begin
      tag_mem[cur_idx]  <= cur_tag;
      line_mem[cur_idx] <= line_data;
    end
  end

  assign read_data = read_data_q;
  assign led       = led_q;
  assign clk_stall = stall_q;
`ifdef DATA_MEM_PERF_EN
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_mem_cache.sv
// Scoreboard bench for data_mem_cache: a word-level memory/residency model predicts each
// access; a monitor times every accepted request and checks data, stall length and LED.
module tb_data_mem_cache;

  localparam int          LINES = 16;
  localparam int          BW    = 1024;
  localparam int          LAT   = 2;
  localparam logic [31:0] LED_A = 32'h2000;

  logic        clk = 1'b0;
  logic        reset, memwrite, memread;
  logic [31:0] addr, write_data, read_data;
  logic [3:0]  sign_mask;
  logic [7:0]  led;
  logic        clk_stall;
`ifdef DATA_MEM_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_mem_cache #(.LINES(LINES), .BACKING_WORDS(BW), .MEM_LATENCY(LAT), .LED_ADDR(LED_A)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .led        (led),
    .clk_stall  (clk_stall)
`ifdef DATA_MEM_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rd;
    logic [31:0] stall;
    logic [7:0]  led;
    logic [31:0] hits;
    logic [31:0] misses;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Reference model: backing words, which word each line currently holds, visible outputs.
  logic [31:0] m_mem [BW];
  int          m_line [LINES];
  logic [31:0] m_rd;
  logic [7:0]  m_led;
  int          m_hits, m_misses;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [31:0] a,
                                           input logic [3:0] m);
    int unsigned sh;
    logic [31:0] v;
    case (m[2:0])
      3'b001: begin
        sh = 32'(a[1:0]) * 8;
        v  = (w >> sh) & 32'hff;
        if (m[3] && v[7]) v = v | 32'hffffff00;
      end
      3'b011: begin
        sh = a[1] ? 16 : 0;
        v  = (w >> sh) & 32'hffff;
        if (m[3] && v[15]) v = v | 32'hffff0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [31:0] a, input logic [3:0] m);
    int unsigned sh;
    logic [31:0] lm;
    case (m[2:0])
      3'b001: begin
        sh = 32'(a[1:0]) * 8;
        lm = 32'hff << sh;
        return (w & ~lm) | ((wd & 32'hff) << sh);
      end
      3'b011: begin
        sh = a[1] ? 16 : 0;
        lm = 32'hffff << sh;
        return (w & ~lm) | ((wd & 32'hffff) << sh);
      end
      default: return wd;
    endcase
  endfunction

  function automatic void push_exp(input int stall, input string name);
    exp_t e;
    e.rd     = m_rd;
    e.stall  = 32'(stall);
    e.led    = m_led;
    e.hits   = 32'(m_hits);
    e.misses = 32'(m_misses);
    exp_q.push_back(e);
    name_q.push_back(name);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) m_line[i] = -1;
    m_rd     = '0;
    m_led    = '0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (clk_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: clk_stall still high after %0d cycles, expected low", name, n);
    end
  endtask

  task automatic do_op(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] m, input string name);
    int unsigned w, idx;
    int stall;
    w   = (a >> 2) % BW;
    idx = w % LINES;
    if (wr) begin
      m_mem[w] = store_merge(m_mem[w], wd, a, m);
      if ((a >> 2) == (LED_A >> 2)) m_led = wd[7:0];
      stall = LAT + 1;
    end else begin
      if (m_line[idx] == int'(w)) begin
        m_hits++;
        stall = 0;
      end else begin
        m_misses++;
        m_line[idx] = int'(w);
        stall = LAT + 1;
      end
      m_rd = load_fmt(m_mem[w], a, m);
    end
    push_exp(stall, name);
    @(negedge clk);
    addr       = a;
    write_data = wd;
    sign_mask  = m;
    memwrite   = wr;
    memread    = rd;
    @(negedge clk);
    memwrite = 1'b0;
    memread  = 1'b0;
    wait_idle(name);
  endtask

  // Monitor: time each accepted request from its sampling edge to completion.
  initial begin
    int   n;
    exp_t e;
    string nm;
    forever begin
      @(posedge clk);
      if (!reset && (memread || memwrite)) begin
        n = 0;
        #1;
        while (clk_stall && n < 100) begin
          n++;
          @(posedge clk);
          #1;
        end
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_txn: got a completed access, expected none queued");
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          check({nm, "_data"}, read_data, e.rd);
          check({nm, "_stall"}, 32'(n), e.stall);
          check({nm, "_led"}, {24'h0, led}, {24'h0, e.led});
`ifdef DATA_MEM_PERF_EN
          check({nm, "_hits"}, hit_count, e.hits);
          check({nm, "_misses"}, miss_count, e.misses);
`endif
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned pool [12];
    logic [2:0]  sizes [5];
    int unsigned w;
    logic [31:0] a;
    logic [3:0]  m;
    logic        wr;

    reset = 1'b1; memwrite = 1'b0; memread = 1'b0;
    addr = '0; write_data = '0; sign_mask = 4'b0111;
    for (int i = 0; i < BW; i++) m_mem[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_read_data", read_data, 32'h0);
    check("rst_led", {24'h0, led}, 32'h0);
    check("rst_stall", {31'h0, clk_stall}, 32'h0);
`ifdef DATA_MEM_PERF_EN
    check("rst_hits", hit_count, 32'h0);
    check("rst_misses", miss_count, 32'h0);
`endif

    do_op(1'b1, 1'b0, 32'h400, 32'h0AAA, 4'b0001, "st_byte");
    do_op(1'b0, 1'b1, 32'h400, 32'h0, 4'b1001, "ld_byte_s_miss");
    do_op(1'b0, 1'b1, 32'h400, 32'h0, 4'b0001, "ld_byte_u_hit");
    check("byte_signed_const", exp_q.size() == 0 ? read_data : 32'hdead, 32'h000000AA);

    do_op(1'b1, 1'b0, 32'h100, 32'h2AAAA, 4'b0011, "st_half");
    do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'b1011, "ld_half_s");
    do_op(1'b0, 1'b1, 32'h100, 32'h0, 4'b0011, "ld_half_u");
    check("half_unsigned_const", read_data, 32'h0000AAAA);

    do_op(1'b1, 1'b0, 32'h40, 32'hAAAAAAAA, 4'b0111, "st_word");
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111, "ld_word");
    do_op(1'b1, 1'b0, 32'h41, 32'h55, 4'b0001, "st_byte_hit");
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111, "ld_word_merged");
    check("merge_const", read_data, 32'hAAAA55AA);

    apply_reset();
    do_op(1'b1, 1'b0, 32'h80, 32'h13572468, 4'b0111, "st_conflict");
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111, "conf_ld_a");
    do_op(1'b0, 1'b1, 32'h80, 32'h0, 4'b0111, "conf_ld_b");
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111, "conf_ld_a2");
`ifdef DATA_MEM_PERF_EN
    check("conf_miss_const", miss_count, 32'd3);
    check("conf_hit_const", hit_count, 32'd0);
`endif

    do_op(1'b1, 1'b0, LED_A, 32'h000000C3, 4'b0111, "st_led");
    check("led_const", {24'h0, led}, 32'h000000C3);
    // Read miss aborted by reset two cycles into its stall.
    model_reset();
    push_exp(2, "rst_abort");
    @(negedge clk);
    addr = 32'h80; sign_mask = 4'b0111; memread = 1'b1;
    @(negedge clk);
    memread = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, 4'b0111, "post_rst_ld");

    do_op(1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0111, "wr_rd_both");
    do_op(1'b0, 1'b1, 32'h200, 32'h0, 4'b0111, "ld_after_both");

    sizes[0] = 3'b001; sizes[1] = 3'b011; sizes[2] = 3'b111;
    sizes[3] = 3'b000; sizes[4] = 3'b101;
    for (int i = 0; i < 12; i++) begin
      pool[i] = (i % 4) + 16 * $urandom_range(0, 63);
      do_op(1'b1, 1'b0, pool[i] * 4, $urandom, 4'b0111, "rnd_init");
    end
    for (int k = 0; k < 80; k++) begin
      w  = pool[$urandom_range(0, 11)];
      a  = w * 4 + $urandom_range(0, 3) + ($urandom_range(0, 3) << 12);
      m  = {1'($urandom_range(0, 1)), sizes[$urandom_range(0, 4)]};
      wr = ($urandom_range(0, 2) == 0);
      do_op(wr, !wr, a, $urandom, m, wr ? "rnd_st" : "rnd_ld");
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
